// File: rtl/tick_frame_sequencer_pkg.sv
// rtl/tick_frame_sequencer_pkg.sv - shared states, class-index helper and default sizing
package tick_frame_sequencer_pkg;

    localparam int DEF_NUM_CLASSES       = 4;
    localparam int DEF_NEURONS_PER_CLASS = 4;
    localparam int CLASS_SHIFT           = $clog2(DEF_NEURONS_PER_CLASS);
    localparam int CLASS_W               = $clog2(DEF_NUM_CLASSES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TICK,
        ST_WAIT,
        ST_ARGMAX,
        ST_DONE
    } state_t;

    function automatic logic [31:0] class_of(input logic [31:0] packet,
                                             input int shift = CLASS_SHIFT);
        return packet >> shift;
    endfunction

endpackage

// File: rtl/tick_frame_sequencer_counter_bank.sv
// rtl/tick_frame_sequencer_counter_bank.sv - per-class saturating spike counters
module class_spike_counter_bank
    import tick_frame_sequencer_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int COUNT_WIDTH = 8,
    parameter int IDX_W       = CLASS_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_inc,
    input  logic [IDX_W-1:0]       i_inc_idx,
    input  logic [IDX_W-1:0]       i_rd_idx,
    output logic [COUNT_WIDTH-1:0] o_rd_count,
    output logic                   o_saturated
);

    localparam logic [COUNT_WIDTH-1:0] L_MAX = '1;

    logic [COUNT_WIDTH-1:0] r_count [NUM_CLASSES];
    logic                   r_saturated;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_count[i] <= '0;
            end
            r_saturated <= 1'b0;
        end else if (i_inc) begin
            // A full counter holds its value; the overflow attempt is only flagged.
            if (r_count[i_inc_idx] == L_MAX) begin
                r_saturated <= 1'b1;
            end else begin
                r_count[i_inc_idx] <= r_count[i_inc_idx] + COUNT_WIDTH'(1);
            end
        end
    end

    assign o_rd_count  = r_count[i_rd_idx];
    assign o_saturated = r_saturated;

endmodule

// File: rtl/tick_frame_sequencer.sv
// rtl/tick_frame_sequencer.sv - frame tick generator, per-class spike tally and argmax result
module tick_frame_sequencer
    import tick_frame_sequencer_pkg::*;
#(
    parameter int NUM_OUTPUTS       = 256,
    parameter int NUM_CLASSES       = DEF_NUM_CLASSES,
    parameter int NEURONS_PER_CLASS = DEF_NEURONS_PER_CLASS,
    parameter int TICKS_PER_FRAME   = 16,
    parameter int PERIOD_WIDTH      = 16,
    parameter int COUNT_WIDTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PERIOD_WIDTH-1:0]        tick_period,
    input  logic [$clog2(NUM_OUTPUTS)-1:0] packet_in,
    input  logic                           packet_in_valid,
    output logic                           tick,
    output logic                           busy,
    output logic [$clog2(NUM_CLASSES)-1:0] result_class,
    output logic [COUNT_WIDTH-1:0]         result_count,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           stray_spike,
    output logic                           saturated
);

    localparam int L_SHIFT = $clog2(NEURONS_PER_CLASS);
    localparam int L_CW    = $clog2(NUM_CLASSES);
    localparam int TIDX_W  = $clog2(TICKS_PER_FRAME);

    state_t                  r_state, w_state_nxt;
    logic [PERIOD_WIDTH-1:0] r_period, r_cyc, w_period_eff;
    logic [TIDX_W-1:0]       r_tick_idx;
    logic [L_CW-1:0]         r_arg_idx, r_best_class, r_result_class, w_cand_class, w_inc_idx;
    logic [COUNT_WIDTH-1:0]  r_best_count, r_result_count, w_cand_count, w_rd_count;
    logic [31:0]             w_class;
    logic                    r_stray, w_counting, w_in_range, w_start_acc, w_cyc_done;
    logic                    w_last_tick, w_last_arg, w_take, w_stray_evt, w_saturated;

    assign w_class      = class_of(32'(packet_in), L_SHIFT);
    assign w_in_range   = w_class < 32'(NUM_CLASSES);
    assign w_inc_idx    = w_class[L_CW-1:0];
    assign w_counting   = (r_state == ST_TICK) || (r_state == ST_WAIT);
    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_period_eff = (tick_period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : tick_period;
    assign w_cyc_done   = r_cyc == PERIOD_WIDTH'(1);
    assign w_last_tick  = r_tick_idx == TIDX_W'(TICKS_PER_FRAME - 1);
    assign w_last_arg   = r_arg_idx == L_CW'(NUM_CLASSES - 1);
    assign w_stray_evt  = packet_in_valid &&
                          ((w_counting && !w_in_range) ||
                           (r_state == ST_ARGMAX) || (r_state == ST_DONE));

    // Index 0 seeds the running best; later entries win only when strictly larger.
    assign w_take       = (r_arg_idx == '0) || (w_rd_count > r_best_count);
    assign w_cand_count = w_take ? w_rd_count : r_best_count;
    assign w_cand_class = w_take ? r_arg_idx  : r_best_class;

    class_spike_counter_bank #(
        .NUM_CLASSES (NUM_CLASSES),
        .COUNT_WIDTH (COUNT_WIDTH),
        .IDX_W       (L_CW)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start_acc),
        .i_inc       (w_counting && packet_in_valid && w_in_range),
        .i_inc_idx   (w_inc_idx),
        .i_rd_idx    (r_arg_idx),
        .o_rd_count  (w_rd_count),
        .o_saturated (w_saturated)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_TICK;
            ST_TICK:   w_state_nxt = ST_WAIT;
            ST_WAIT:   if (w_cyc_done) w_state_nxt = w_last_tick ? ST_ARGMAX : ST_TICK;
            ST_ARGMAX: if (w_last_arg) w_state_nxt = ST_DONE;
            ST_DONE:   if (result_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period       <= '0;
            r_cyc          <= '0;
            r_tick_idx     <= '0;
            r_arg_idx      <= '0;
            r_best_class   <= '0;
            r_best_count   <= '0;
            r_result_class <= '0;
            r_result_count <= '0;
            r_stray        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_period   <= w_period_eff;
                    r_tick_idx <= '0;
                    r_stray    <= 1'b0;
                end
                ST_TICK: r_cyc <= r_period - PERIOD_WIDTH'(1);
                ST_WAIT: if (w_cyc_done) begin
                    r_arg_idx <= '0;
                    if (!w_last_tick) r_tick_idx <= r_tick_idx + TIDX_W'(1);
                end else begin
                    r_cyc <= r_cyc - PERIOD_WIDTH'(1);
                end
                ST_ARGMAX: begin
                    r_best_class <= w_cand_class;
                    r_best_count <= w_cand_count;
                    r_arg_idx    <= r_arg_idx + L_CW'(1);
                    if (w_last_arg) begin
                        r_result_class <= w_cand_class;
                        r_result_count <= w_cand_count;
                    end
                end
                default: ;
            endcase
            if (w_stray_evt) r_stray <= 1'b1;
        end
    end

    assign tick         = r_state == ST_TICK;
    assign busy         = r_state != ST_IDLE;
    assign result_valid = r_state == ST_DONE;
    assign result_class = r_result_class;
    assign result_count = r_result_count;
    assign stray_spike  = r_stray;
    assign saturated    = w_saturated;

endmodule

// File: tb/tb_tick_frame_sequencer.sv
// tb/tb_tick_frame_sequencer.sv - self-checking bench for tick_frame_sequencer
module tb_tick_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, packet_in_valid, result_ready;
    logic [15:0] tick_period;
    logic [7:0]  packet_in;

    logic        tick, busy, result_valid, stray_spike, saturated;
    logic [1:0]  result_class;
    logic [7:0]  result_count;
    logic        tick_4, busy_4, result_valid_4, stray_4, sat_4;
    logic [1:0]  result_class_4;
    logic [3:0]  result_count_4;

    always #5 clk = ~clk;

    tick_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .tick_period(tick_period),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .tick(tick), .busy(busy), .result_class(result_class),
        .result_count(result_count), .result_valid(result_valid),
        .result_ready(result_ready), .stray_spike(stray_spike), .saturated(saturated)
    );

    tick_frame_sequencer #(.COUNT_WIDTH(4)) dut_w4 (
        .clk(clk), .rst(rst), .start(start), .tick_period(tick_period),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .tick(tick_4), .busy(busy_4), .result_class(result_class_4),
        .result_count(result_count_4), .result_valid(result_valid_4),
        .result_ready(result_ready), .stray_spike(stray_4), .saturated(sat_4)
    );

    typedef struct {
        int              period;
        logic [3:0][7:0] pkt;
        logic [3:0][7:0] cnt;
        bit              argmax_spike;
        int              hold;
    } vec_t;

    typedef struct {
        int cls; int cnt; int stray; int sat;
        int cls4; int cnt4; int sat4;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(vec_t v);
        exp_t e;
        int   raw[4];
        int   c;
        e = '{default: 0};
        for (int i = 0; i < 4; i++) raw[i] = 0;
        if (v.argmax_spike) e.stray = 1;
        for (int i = 0; i < 4; i++) begin
            if (v.cnt[i] != 0) begin
                c = int'(v.pkt[i]) >> 2;
                if (c < 4) raw[c] += int'(v.cnt[i]);
                else       e.stray = 1;
            end
        end
        e.cnt  = -1;
        e.cnt4 = -1;
        for (int i = 0; i < 4; i++) begin
            int a;
            int b;
            a = (raw[i] > 255) ? 255 : raw[i];
            b = (raw[i] > 15)  ? 15  : raw[i];
            if (raw[i] > 255) e.sat  = 1;
            if (raw[i] > 15)  e.sat4 = 1;
            if (a > e.cnt)  begin e.cnt  = a; e.cls  = i; end
            if (b > e.cnt4) begin e.cnt4 = b; e.cls4 = i; end
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t       e;
        logic [7:0] spk[$];
        int         pe, k, ticks, last, bad_gaps, got, errs;
        pe = (v.period < 2) ? 2 : v.period;
        for (int i = 3; i >= 0; i--)
            for (int j = 0; j < int'(v.cnt[i]); j++) spk.push_back(v.pkt[i]);
        sb.push_back(model(v));
        tick_period = 16'(v.period);
        start = 1'b1;
        ticks = 0; last = 0; bad_gaps = 0; got = 0;
        for (k = 1; k <= 16 * pe + 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b0;
                chk("first_tick", int'(tick), 1);
                chk("flags_cleared", int'({stray_spike, saturated, stray_4, sat_4}), 0);
            end
            if (tick) begin
                ticks++;
                if (last != 0 && k - last != pe) bad_gaps++;
                last = k;
            end
            if (result_valid) begin got = k; break; end
            if (spk.size() > 0) begin
                packet_in = spk.pop_front(); packet_in_valid = 1'b1;
            end else if (v.argmax_spike && k == 16 * pe + 2) begin
                packet_in = 8'd0; packet_in_valid = 1'b1;
            end else begin
                packet_in_valid = 1'b0;
            end
        end
        packet_in_valid = 1'b0;
        chk("tick_count", ticks, 16);
        chk("tick_gaps", bad_gaps, 0);
        chk("result_latency", got, 16 * pe + 5);
        e = sb.pop_front();
        chk("result_class", int'(result_class), e.cls);
        chk("result_count", int'(result_count), e.cnt);
        chk("stray_spike", int'(stray_spike), e.stray);
        chk("saturated", int'(saturated), e.sat);
        chk("w4_result_class", int'(result_class_4), e.cls4);
        chk("w4_result_count", int'(result_count_4), e.cnt4);
        chk("w4_saturated", int'(sat_4), e.sat4);
        errs = 0;
        for (int h = 0; h < v.hold; h++) begin
            start = h[0];
            @(posedge clk); #1;
            if (!result_valid || !busy || int'(result_class) != e.cls ||
                int'(result_count) != e.cnt || !result_valid_4) errs++;
        end
        start = 1'b0;
        if (v.hold > 0) chk("hold_stable", errs, 0);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(result_valid), 0);
        chk("retained_class", int'(result_class), e.cls);
        chk("retained_count", int'(result_count), e.cnt);
        packet_in = 8'd200; packet_in_valid = 1'b1;
        @(posedge clk); #1;
        packet_in_valid = 1'b0;
        chk("idle_spike_silent", int'(stray_spike), e.stray);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tick"},  int'(tick), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_class"}, int'(result_class), 0);
        chk({tag, "_count"}, int'(result_count), 0);
        chk({tag, "_stray"}, int'(stray_spike), 0);
        chk({tag, "_sat"},   int'(saturated), 0);
        chk({tag, "_w4"},    int'({tick_4, busy_4, result_valid_4, sat_4}), 0);
    endtask

    initial begin
        int ticks, n;
        rst = 1'b1; start = 1'b0; packet_in_valid = 1'b0; result_ready = 1'b0;
        tick_period = 16'd5; packet_in = 8'd0;

        vecs[0] = '{5, 32'h0, 32'h0, 1'b0, 0};
        vecs[1] = '{4, {8'd9, 8'd10, 8'd11, 8'd1}, {8'd3, 8'd3, 8'd3, 8'd2}, 1'b0, 0};
        vecs[2] = '{3, {8'd12, 8'd4, 16'd0}, {8'd20, 8'd15, 16'd0}, 1'b0, 10};
        vecs[3] = '{2, {8'd5, 8'd200, 16'd0}, {8'd1, 8'd1, 16'd0}, 1'b1, 0};
        vecs[4] = '{2, {8'd2, 24'd0}, {8'd1, 24'd0}, 1'b0, 0};
        vecs[5] = '{0, {8'd7, 24'd0}, {8'd3, 24'd0}, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        tick_period = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ticks = 0; n = 0;
        while (ticks < 7 && n < 200) begin
            if (tick) ticks++;
            if (ticks < 7) begin @(posedge clk); #1; n++; end
        end
        chk("reached_tick7", ticks, 7);
        tick_period = 16'd0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midframe_reset");
        ticks = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (tick) ticks++;
        end
        chk("no_tick_after_reset", ticks, 0);

        run_vec(vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
